// File: rtl/report_stream_pkg.sv
// Shared types and constants for the report frame streamer: FSM state encoding,
// byte width and the default tag base.
package report_stream_pkg;

  localparam int BYTE_W = 8;
  localparam int MAX_CH = 8;
  localparam int CH_W = 3;
  localparam logic [BYTE_W-1:0] DEFAULT_TAG_BASE = 8'h55;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    TAG  = 3'd3,
    DAT  = 3'd4,
    SUM  = 3'd5,
    NEXT = 3'd6
  } state_t;

endpackage

// File: rtl/stream_byte_out.sv
// Output byte register for a valid/ready byte stream. A load pulse captures a
// byte and raises valid; valid drops on the handshake unless a new byte loads.
module stream_byte_out
  import report_stream_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              tx_ready_i,
  output logic [BYTE_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  output logic              hs_o
);

  logic [BYTE_W-1:0] data_q;
  logic              valid_q;

  // Transfer handshake: valid and ready together in one cycle.
  assign hs_o       = valid_q && tx_ready_i;
  assign tx_data_o  = data_q;
  assign tx_valid_o = valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= byte_i;
      valid_q <= 1'b1;
    end else if (hs_o) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/report_frame_streamer.sv
// Walks report BRAMs over 0..last_addr and serialises each record as tag/data
// byte pairs plus an optional mod-256 checksum onto a valid/ready byte stream.
module report_frame_streamer
  import report_stream_pkg::*;
#(
  parameter int                NUM_CH      = 3,
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 8,
  parameter logic [BYTE_W-1:0] TAG_BASE    = DEFAULT_TAG_BASE,
  parameter bit                CHECKSUM_EN = 1'b1
) (
  input  logic                     CLK,
  input  logic                     CPU_RESETN,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        last_addr,
  output logic                     bram_en,
  output logic [ADDR_W-1:0]        bram_addr,
  input  logic [NUM_CH*DATA_W-1:0] bram_rdata,
  output logic [BYTE_W-1:0]        tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W:0]          rec_count,
  output logic [2:0]               dbg_state
);

  if (DATA_W != BYTE_W || NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_param
    $error("report_frame_streamer: DATA_W must be 8 and NUM_CH must be 1..8");
  end

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W:0]   rec_cnt_q;
  logic [CH_W-1:0]   ch_q;
  logic [BYTE_W-1:0] sum_q;
  logic [BYTE_W-1:0] rec_q [MAX_CH];
  logic              bram_en_q;
  logic              busy_q;
  logic              done_q;

  logic              hs;
  logic              load;
  logic              rec_end;
  logic [BYTE_W-1:0] load_byte;
  logic [BYTE_W-1:0] ch_byte;

  assign ch_byte = rec_q[ch_q];

  // The last handshake of a record: final data byte without checksum, or the sum byte.
  assign rec_end = hs && ((state_q == DAT && ch_q == LAST_CH && !CHECKSUM_EN) ||
                          state_q == SUM);

  always_comb begin
    load      = 1'b0;
    load_byte = '0;
    case (state_q)
      CAP: begin
        load      = 1'b1;
        load_byte = TAG_BASE;
      end
      TAG: begin
        if (hs) begin
          load      = 1'b1;
          load_byte = ch_byte;
        end
      end
      DAT: begin
        if (hs) begin
          if (ch_q != LAST_CH) begin
            load      = 1'b1;
            load_byte = TAG_BASE + {{(BYTE_W-CH_W){1'b0}}, ch_q + 3'd1};
          end else if (CHECKSUM_EN) begin
            load      = 1'b1;
            load_byte = sum_q + ch_byte;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      last_q    <= '0;
      rec_cnt_q <= '0;
      ch_q      <= '0;
      sum_q     <= '0;
      bram_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < MAX_CH; i++) rec_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            last_q    <= last_addr;
            addr_q    <= '0;
            rec_cnt_q <= '0;
            busy_q    <= 1'b1;
            bram_en_q <= 1'b1;
            state_q   <= RD;
          end
        end
        RD: begin
          bram_en_q <= 1'b0;
          state_q   <= CAP;
        end
        CAP: begin
          for (int i = 0; i < NUM_CH; i++) rec_q[i] <= bram_rdata[i*BYTE_W +: BYTE_W];
          sum_q   <= '0;
          ch_q    <= '0;
          state_q <= TAG;
        end
        TAG: begin
          if (hs) state_q <= DAT;
        end
        DAT: begin
          if (hs) begin
            sum_q <= sum_q + ch_byte;
            if (ch_q != LAST_CH) begin
              ch_q    <= ch_q + 3'd1;
              state_q <= TAG;
            end else if (CHECKSUM_EN) begin
              state_q <= SUM;
            end
          end
        end
        SUM: begin
          state_q <= SUM;
        end
        NEXT: begin
          done_q <= 1'b0;
          if (addr_q == last_q) begin
            state_q <= IDLE;
          end else begin
            addr_q    <= addr_q + ADDR_W'(1);
            bram_en_q <= 1'b1;
            state_q   <= RD;
          end
        end
        default: state_q <= IDLE;
      endcase
      // done and busy change on entry to NEXT so done lands one cycle after the final byte.
      if (rec_end) begin
        state_q   <= NEXT;
        rec_cnt_q <= rec_cnt_q + (ADDR_W+1)'(1);
        if (addr_q == last_q) begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
      end
    end
  end

  stream_byte_out u_byte_out (
    .clk_i      (CLK),
    .rst_ni     (CPU_RESETN),
    .load_i     (load),
    .byte_i     (load_byte),
    .tx_ready_i (tx_ready),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .hs_o       (hs)
  );

  assign bram_en   = bram_en_q;
  assign bram_addr = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rec_count = rec_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_report_frame_streamer.sv
// Bench for report_frame_streamer: a frame-level byte/address model checked on
// every cycle, plus literal expectations for the documented example frames.
module tb_report_frame_streamer;
  import report_stream_pkg::*;

  logic        clk;
  logic        rst_n;

  logic        start, tx_ready, bram_en, tx_valid, busy, done;
  logic [7:0]  last_addr, bram_addr, tx_data;
  logic [23:0] bram_rdata;
  logic [8:0]  rec_count;
  logic [2:0]  dbg_state;

  logic        start1, tx_ready1, bram_en1, tx_valid1, busy1, done1;
  logic [7:0]  last_addr1, bram_addr1, tx_data1, bram_rdata1;
  logic [8:0]  rec_count1;
  logic [2:0]  dbg_state1;

  logic [23:0] mem  [256];
  logic [7:0]  mem1 [256];

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_hs_cyc = 0;
  int          done_count = 0;
  int          done1_count = 0;
  int          exp_recs = 0;
  bit          rnd_ready = 0;
  bit          stall_q = 0;
  bit          stall1_q = 0;
  logic [7:0]  stall_data, stall1_data;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_addr_q[$];
  logic [7:0]  got_q[$];
  logic [7:0]  exp1_q[$];
  logic [7:0]  got1_q[$];
  logic [7:0]  lit1 [7];

  report_frame_streamer dut (
    .CLK(clk), .CPU_RESETN(rst_n), .start(start), .last_addr(last_addr),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_rdata(bram_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .rec_count(rec_count), .dbg_state(dbg_state)
  );

  report_frame_streamer #(.NUM_CH(1), .CHECKSUM_EN(1'b0)) dut1 (
    .CLK(clk), .CPU_RESETN(rst_n), .start(start1), .last_addr(last_addr1),
    .bram_en(bram_en1), .bram_addr(bram_addr1), .bram_rdata(bram_rdata1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .busy(busy1), .done(done1), .rec_count(rec_count1), .dbg_state(dbg_state1)
  );

  // Clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1, "watchdog");
  end

  // One-cycle-latency BRAM models
  always @(posedge clk) if (bram_en) bram_rdata <= mem[bram_addr];
  always @(posedge clk) if (bram_en1) bram_rdata1 <= mem1[bram_addr1];

  initial begin
    tx_ready  = 1'b1;
    tx_ready1 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tx_ready1 = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=%0h req=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: every record is tag/data per channel, then the mod-256 data sum.
  task automatic build_model(input int last);
    int sum;
    logic [7:0] b;
    exp_recs = last + 1;
    for (int a = 0; a <= last; a++) begin
      sum = 0;
      exp_addr_q.push_back(8'(a));
      for (int c = 0; c < 3; c++) begin
        b = mem[a][c*8 +: 8];
        exp_q.push_back(8'((85 + c) % 256));
        exp_q.push_back(b);
        sum = sum + int'(b);
      end
      exp_q.push_back(8'(sum % 256));
    end
  endtask

  // Scoreboard for the 3-channel instance
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 0;
    end else begin
      cyc++;
      if (bram_en) begin
        check("addr_expected", 32'(exp_addr_q.size() > 0), 1);
        if (exp_addr_q.size() > 0) check("bram_addr", bram_addr, exp_addr_q.pop_front());
      end
      if (stall_q) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, stall_data);
      end
      if (tx_valid && tx_ready) begin
        last_hs_cyc = cyc;
        got_q.push_back(tx_data);
        check("byte_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("tx_byte", tx_data, exp_q.pop_front());
      end
      if (done) begin
        done_count++;
        check("done_gap", cyc - last_hs_cyc, 1);
        check("done_busy", busy, 0);
        check("done_drained", exp_q.size(), 0);
        check("done_rec_count", rec_count, exp_recs);
      end
      stall_q = tx_valid && !tx_ready;
      stall_data = tx_data;
    end
  end

  // Scoreboard for the 1-channel, no-checksum instance
  always @(negedge clk) begin
    if (!rst_n) begin
      stall1_q = 0;
    end else begin
      if (stall1_q) begin
        check("hold_valid1", tx_valid1, 1);
        check("hold_data1", tx_data1, stall1_data);
      end
      if (tx_valid1 && tx_ready1) begin
        got1_q.push_back(tx_data1);
        check("byte_expected1", 32'(exp1_q.size() > 0), 1);
        if (exp1_q.size() > 0) check("tx_byte1", tx_data1, exp1_q.pop_front());
      end
      if (done1) begin
        done1_count++;
        check("done1_drained", exp1_q.size(), 0);
        check("done1_rec_count", rec_count1, 1);
      end
      stall1_q = tx_valid1 && !tx_ready1;
      stall1_data = tx_data1;
    end
  end

  // Driver tasks
  task automatic pulse_start(input logic [7:0] last);
    @(posedge clk);
    #1;
    last_addr = last;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit start_in_done);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    check("done_seen", done, 1);
    if (start_in_done) begin
      last_addr = 8'd7;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic wait_bytes(input int nbytes, input int budget);
    int n = 0;
    while (got_q.size() < nbytes && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("bytes_reached", 32'(got_q.size() >= nbytes), 1);
  endtask

  task automatic idle_check(input int cycles, input int recs);
    repeat (cycles) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_bram_en", bram_en, 0);
      check("idle_valid", tx_valid, 0);
      check("idle_rec_count", rec_count, recs);
    end
  endtask

  task automatic run_frame(input int last, input int budget);
    int d0 = done_count;
    got_q.delete();
    pulse_start(8'(last));
    wait_done(budget, 0);
    idle_check(3, last + 1);
    check("frame_bytes", got_q.size(), (last + 1) * 7);
    check("frame_done_once", done_count - d0, 1);
    check("frame_addrs_used", exp_addr_q.size(), 0);
  endtask

  initial begin
    int d0;
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    start1 = 1'b0;
    last_addr = '0;
    last_addr1 = '0;
    lit1 = '{8'h55, 8'h01, 8'h56, 8'h02, 8'h57, 8'h03, 8'h06};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bram_en", bram_en, 0);
    check("rst_bram_addr", bram_addr, 0);
    check("rst_rec_count", rec_count, 0);
    check("rst_valid1", tx_valid1, 0);
    check("rst_busy1", busy1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single record, documented example bytes and start-up latency
    mem[0] = 24'h030201;
    build_model(0);
    for (int i = 0; i < 7; i++) check("model_pin", exp_q[i], lit1[i]);
    got_q.delete();
    d0 = done_count;
    pulse_start(8'd0);
    @(negedge clk);
    check("lat_rd_bram_en", bram_en, 1);
    check("lat_rd_addr", bram_addr, 0);
    check("lat_rd_valid", tx_valid, 0);
    check("lat_rd_busy", busy, 1);
    @(negedge clk);
    check("lat_cap_bram_en", bram_en, 0);
    check("lat_cap_valid", tx_valid, 0);
    @(negedge clk);
    check("lat_tag_valid", tx_valid, 1);
    check("lat_tag_data", tx_data, 8'h55);
    wait_done(100, 0);
    idle_check(3, 1);
    check("t1_bytes", got_q.size(), 7);
    for (int i = 0; i < 7 && i < got_q.size(); i++) check("t1_literal", got_q[i], lit1[i]);
    check("t1_done_once", done_count - d0, 1);

    // Three records, addresses read once in order
    for (int a = 0; a < 3; a++) mem[a] = 24'($urandom);
    build_model(2);
    run_frame(2, 200);

    // One channel, no checksum, random back-pressure
    mem1[0] = 8'hFF;
    exp1_q = '{8'h55, 8'hFF};
    got1_q.delete();
    d0 = done1_count;
    @(posedge clk);
    #1;
    last_addr1 = 8'd0;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done1 && n < 200);
    check("t3_done_seen", done1, 1);
    repeat (3) @(negedge clk);
    check("t3_bytes", got1_q.size(), 2);
    if (got1_q.size() == 2) begin
      check("t3_tag", got1_q[0], 8'h55);
      check("t3_data", got1_q[1], 8'hFF);
    end
    check("t3_done_once", done1_count - d0, 1);

    // Checksum wraps mod 256
    mem[0] = 24'h03FFFF;
    build_model(0);
    check("model_sum_pin", exp_q[6], 8'h01);
    run_frame(0, 100);
    if (got_q.size() == 7) check("t4_sum_byte", got_q[6], 8'h01);

    // start mid-frame and in the done cycle must be ignored
    rnd_ready = 1;
    for (int a = 0; a < 3; a++) mem[a] = 24'($urandom);
    build_model(2);
    got_q.delete();
    d0 = done_count;
    pulse_start(8'd2);
    wait_bytes(5, 200);
    @(posedge clk);
    #1;
    last_addr = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(500, 1);
    idle_check(6, 3);
    check("t5_bytes", got_q.size(), 21);
    check("t5_done_once", done_count - d0, 1);
    rnd_ready = 0;

    // Reset after the 4th byte, then a fresh full frame
    for (int a = 0; a < 2; a++) mem[a] = 24'($urandom);
    build_model(1);
    got_q.delete();
    pulse_start(8'd1);
    wait_bytes(4, 100);
    check("t6_valid_before_rst", tx_valid, 1);
    check("t6_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", tx_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_bram_en", bram_en, 0);
    check("t6_rst_rec_count", rec_count, 0);
    exp_q.delete();
    exp_addr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    build_model(1);
    run_frame(1, 100);
    if (got_q.size() > 0) check("t6_first_tag", got_q[0], 8'h55);

    // Full address range, no wrap past the top address
    for (int a = 0; a < 256; a++) mem[a] = 24'($urandom);
    build_model(255);
    run_frame(255, 4000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
